// File: rtl/stack_arbiter.sv
// Round-robin arbiter that lets two requesters share one LIFO stack.
// Illegal ops (push on FULL, pop on EMPTY) are refused so the stack never flags ERROR.
module stack_arbiter #(
    parameter int WL = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          op0,
    input  logic [WL-1:0] wdata0,
    input  logic          req1,
    input  logic          op1,
    input  logic [WL-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          reject0,
    output logic          reject1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [WL-1:0] rdata,
    output logic          busy,
    output logic          s_wReq,
    output logic          s_rReq,
    output logic [WL-1:0] s_din,
    input  logic [WL-1:0] s_dout,
    input  logic          s_FULL,
    input  logic          s_EMPTY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          op_q, op_d;
    logic [WL-1:0] data_q, data_d;
    logic [WL-1:0] rdata_q, rdata_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic winner_s;
    logic win_op_s;
    logic legal_s;
    logic arb_s;

    // Requests are only considered in IDLE and never while reset is asserted.
    assign winner_s = (req0 && req1) ? prio_q : req1;
    assign win_op_s = winner_s ? op1 : op0;
    assign legal_s  = win_op_s ? ~s_FULL : ~s_EMPTY;
    assign arb_s    = (state_q == IDLE) && !RST && (req0 || req1);

    assign gnt0    = arb_s &  legal_s & ~winner_s;
    assign gnt1    = arb_s &  legal_s &  winner_s;
    assign reject0 = arb_s & ~legal_s & ~winner_s;
    assign reject1 = arb_s & ~legal_s &  winner_s;

    assign s_wReq  = (state_q == ISSUE) &&  op_q;
    assign s_rReq  = (state_q == ISSUE) && !op_q;
    assign s_din   = data_q;
    assign busy    = (state_q != IDLE);
    assign rdata   = rdata_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

    // Next-state logic: arbitration in IDLE, one-cycle strobe in ISSUE, pop capture.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        op_d      = op_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_s) begin
                    prio_d = ~winner_s;
                    if (legal_s) begin
                        owner_d = winner_s;
                        op_d    = win_op_s;
                        data_d  = winner_s ? wdata1 : wdata0;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = op_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                rdata_d   = s_dout;
                rvalid0_d = ~owner_q;
                rvalid1_d =  owner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            op_q      <= 1'b0;
            data_q    <= {WL{1'b0}};
            rdata_q   <= {WL{1'b0}};
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a 4-deep LIFO stack stand-in, a transaction-level
// expectation model checked every cycle, directed scenarios, then random traffic.
module tb_stack_arbiter;
    localparam int WL    = 4;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
    logic [WL-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, reject0, reject1, rvalid0, rvalid1, busy, s_wReq, s_rReq;
    logic [WL-1:0] rdata, s_din;
    logic [WL-1:0] s_dout = '0;
    logic          s_FULL, s_EMPTY;

    stack_arbiter #(.WL(WL)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .op0(op0), .wdata0(wdata0),
        .req1(req1), .op1(op1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .reject0(reject0), .reject1(reject1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy),
        .s_wReq(s_wReq), .s_rReq(s_rReq), .s_din(s_din),
        .s_dout(s_dout), .s_FULL(s_FULL), .s_EMPTY(s_EMPTY)
    );

    always #5 CLK = ~CLK;

    // Stack stand-in: acts on strobes at the edge, dout valid the cycle after rReq.
    logic [WL-1:0] mem [DEPTH];
    logic [2:0]    sp = 3'd0;
    logic          stk_err = 1'b0;
    assign s_FULL  = (sp == 3'd4);
    assign s_EMPTY = (sp == 3'd0);

    always @(posedge CLK) begin
        if (RST) begin
            sp     <= 3'd0;
            s_dout <= '0;
        end else begin
            if ((s_wReq === 1'b1 && sp == 3'd4) || (s_rReq === 1'b1 && sp == 3'd0) ||
                (s_wReq === 1'b1 && s_rReq === 1'b1))
                stk_err <= 1'b1;
            if (s_wReq === 1'b1 && s_rReq !== 1'b1 && sp != 3'd4) begin
                mem[sp[1:0]] <= s_din;
                sp <= sp + 3'd1;
            end else if (s_rReq === 1'b1 && s_wReq !== 1'b1 && sp != 3'd0) begin
                s_dout <= mem[sp[1:0] - 2'd1];
                sp <= sp - 3'd1;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expectation model: a queue for stack contents plus per-cycle scheduled events.
    bit            m_on   = 1'b0;
    bit            m_prio = 1'b0;
    int            m_free = 0;
    logic [WL-1:0] m_rdata = '0;
    logic [WL-1:0] m_stk[$];
    bit            r_wreq[8], r_rreq[8], r_rv0[8], r_rv1[8];
    logic [WL-1:0] r_din[8], r_rd[8];

    task automatic clear_slots();
        for (int i = 0; i < 8; i++) begin
            r_wreq[i] = 0; r_rreq[i] = 0; r_rv0[i] = 0; r_rv1[i] = 0;
            r_din[i] = '0; r_rd[i] = '0;
        end
    endtask

    task automatic monitor();
        int s;
        bit w, op, legal, e_g0, e_g1, e_j0, e_j1, e_busy;
        logic [WL-1:0] d, v;
        forever begin
            @(negedge CLK);
            if (m_on) begin
                s = cyc % 8;
                e_g0 = 0; e_g1 = 0; e_j0 = 0; e_j1 = 0;
                if (r_rv0[s] || r_rv1[s]) m_rdata = r_rd[s];
                e_busy = (cyc < m_free);
                if (!RST && cyc >= m_free && (req0 || req1)) begin
                    w  = (req0 && req1) ? m_prio : req1;
                    op = w ? op1 : op0;
                    d  = w ? wdata1 : wdata0;
                    legal = op ? (m_stk.size() < DEPTH) : (m_stk.size() > 0);
                    m_prio = !w;
                    if (legal) begin
                        if (w) e_g1 = 1; else e_g0 = 1;
                        if (op) begin
                            m_stk.push_back(d);
                            r_wreq[(cyc + 1) % 8] = 1;
                            r_din[(cyc + 1) % 8]  = d;
                            m_free = cyc + 2;
                        end else begin
                            v = m_stk.pop_back();
                            r_rreq[(cyc + 1) % 8] = 1;
                            if (w) r_rv1[(cyc + 3) % 8] = 1; else r_rv0[(cyc + 3) % 8] = 1;
                            r_rd[(cyc + 3) % 8] = v;
                            m_free = cyc + 3;
                        end
                    end else begin
                        if (w) e_j1 = 1; else e_j0 = 1;
                    end
                end
                chk("gnt0", gnt0, e_g0);
                chk("gnt1", gnt1, e_g1);
                chk("reject0", reject0, e_j0);
                chk("reject1", reject1, e_j1);
                chk("busy", busy, e_busy);
                chk("s_wReq", s_wReq, r_wreq[s]);
                chk("s_rReq", s_rReq, r_rreq[s]);
                if (r_wreq[s]) chk("s_din", s_din, r_din[s]);
                chk("s_din_known", $isunknown(s_din), 0);
                chk("rvalid0", rvalid0, r_rv0[s]);
                chk("rvalid1", rvalid1, r_rv1[s]);
                chk("rdata", rdata, m_rdata);
                chk("stack_error", stk_err, 0);
                r_wreq[s] = 0; r_rreq[s] = 0; r_rv0[s] = 0; r_rv1[s] = 0;
            end
            if (RST) begin
                m_on = 1; m_free = cyc + 1; m_prio = 0; m_rdata = '0;
                m_stk.delete();
                clear_slots();
            end
            cyc++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raises req for one requester, holds it until gnt/reject, drops it on the next edge.
    task automatic do_req(input int r, input logic op, input logic [WL-1:0] d,
                          output int res, output int t);
        if (r == 0) begin req0 = 1'b1; op0 = op; wdata0 = d; end
        else        begin req1 = 1'b1; op1 = op; wdata1 = d; end
        res = 0;
        t = 0;
        for (int k = 0; k < 30 && res == 0; k++) begin
            #2;
            if ((r == 0) ? gnt0 : gnt1) res = 1;
            else if ((r == 0) ? reject0 : reject1) res = 2;
            t = cyc;
            tick();
        end
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
        chk("handshake_done", (res != 0), 1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic pop_chk(input int r, input logic [WL-1:0] exp, input string nm);
        int res, t;
        do_req(r, 1'b0, '0, res, t);
        chk({nm, "_gnt"}, res, 1);
        tick();
        tick();
        chk({nm, "_rvalid_own"}, (r == 0) ? rvalid0 : rvalid1, 1);
        chk({nm, "_rvalid_other"}, (r == 0) ? rvalid1 : rvalid0, 0);
        chk({nm, "_rdata"}, rdata, exp);
    endtask

    initial begin
        int ra, rb, ta, tb;
        clear_slots();
        fork
            monitor();
        join_none
        do_reset();

        // 1: single push, strobe and busy in the following cycle only
        do_req(0, 1'b1, 4'h1, ra, ta);
        chk("t1_gnt0", ra, 1);
        chk("t1_s_wReq", s_wReq, 1);
        chk("t1_s_din", s_din, 4'h1);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_busy_done", busy, 0);

        // 2: simultaneous pushes after reset; requester 0 first, requester 1 two cycles later
        do_reset();
        fork
            do_req(0, 1'b1, 4'h2, ra, ta);
            do_req(1, 1'b1, 4'h3, rb, tb);
        join
        chk("t2_gnt0", ra, 1);
        chk("t2_gnt1", rb, 1);
        chk("t2_gap", tb - ta, 2);
        pop_chk(0, 4'h3, "t2_pop_a");
        pop_chk(0, 4'h2, "t2_pop_b");

        // 3: fill the stack, then a push must be refused
        for (int i = 0; i < DEPTH; i++) begin
            do_req(0, 1'b1, 4'(i + 8), ra, ta);
            chk("t3_fill", ra, 1);
        end
        tick();
        do_req(1, 1'b1, 4'h7, rb, tb);
        chk("t3_reject1", rb, 2);
        chk("t3_no_wreq", s_wReq, 0);

        // 4: pop on empty refused, which hands priority to requester 1
        do_reset();
        do_req(0, 1'b0, '0, ra, ta);
        chk("t4_reject0", ra, 2);
        fork
            do_req(0, 1'b1, 4'h9, ra, ta);
            do_req(1, 1'b1, 4'hA, rb, tb);
        join
        chk("t4_req1_first", (tb < ta), 1);

        // 5: two pushes, then a pop by requester 1 returns the last pushed word
        do_reset();
        do_req(0, 1'b1, 4'h3, ra, ta);
        do_req(0, 1'b1, 4'h5, ra, ta);
        pop_chk(1, 4'h5, "t5_pop");

        // 6: reset during CAPTURE cancels the pop result
        do_req(0, 1'b0, '0, ra, ta);
        chk("t6_gnt0", ra, 1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t6_rvalid0", rvalid0, 0);
        chk("t6_rvalid1", rvalid1, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rdata", rdata, 4'h0);
        chk("t6_s_din", s_din, 4'h0);
        chk("t6_s_rReq", s_rReq, 0);

        // Random traffic from both requesters with occasional resets
        fork
            begin
                int res, t;
                for (int k = 0; k < 250; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    do_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), res, t);
                end
            end
            begin
                int res, t;
                for (int k = 0; k < 250; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    do_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), res, t);
                end
            end
            begin
                for (int k = 0; k < 1500; k++) begin
                    tick();
                    RST = ($urandom_range(0, 299) == 0);
                end
                RST = 1'b0;
            end
        join
        RST = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
